// File: rtl/sa2x2_ctrl_pkg.sv
// rtl/sa2x2_ctrl_pkg.sv - shared types and defaults for the sa2x2 sequencer
package sa2x2_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_FEED    = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_CAPTURE = 3'd4
    } state_t;

    localparam int DEF_DW        = 8;
    localparam int DEF_OW        = 8;
    localparam int DEF_K         = 9;
    localparam int DEF_AW        = 4;
    localparam int DEF_DRAIN_LAT = 3;

    // Feed steps needed to push K elements through two lanes with a one-step lane-1 skew.
    function automatic int nstep(input int k);
        return k / 2 + 1;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sa2x2_ctrl_op_buf.sv
// rtl/sa2x2_ctrl_op_buf.sv - K x DW operand register file, one write port, two async read ports
module sa2x2_ctrl_op_buf #(
    parameter int DW = 8,
    parameter int K  = 9,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr0,
    input  logic [AW-1:0] raddr1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1
);

    logic [DW-1:0] mem [K];

    // Only indices 0..K-1 can match, so out-of-range writes fall through silently.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < K; i++) mem[i] <= '0;
        end else begin
            for (int i = 0; i < K; i++) begin
                if (we && waddr == AW'(i)) mem[i] <= wdata;
            end
        end
    end

    assign rdata0 = (int'(raddr0) < K) ? mem[raddr0] : '0;
    assign rdata1 = (int'(raddr1) < K) ? mem[raddr1] : '0;

endmodule

// File: rtl/sa2x2_ctrl.sv
// rtl/sa2x2_ctrl.sv - sequencer that streams two operand vectors into sa2x2 and captures the dot product
import sa2x2_ctrl_pkg::*;

module sa2x2_ctrl #(
    parameter int DW        = DEF_DW,
    parameter int OW        = DEF_OW,
    parameter int K         = DEF_K,
    parameter int AW        = DEF_AW,
    parameter int DRAIN_LAT = DEF_DRAIN_LAT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_en,
    input  logic          ld_sel,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [OW-1:0] result,
    output logic          sa_clear,
    output logic [DW-1:0] sa_din0,
    output logic [DW-1:0] sa_din1,
    output logic [DW-1:0] sa_win0,
    output logic [DW-1:0] sa_win1,
    input  logic [OW-1:0] sa_out
);

    localparam int            NSTEP = nstep(K);
    localparam int            CW    = $clog2(max2(NSTEP, DRAIN_LAT));
    localparam logic [AW:0]   KW    = (AW + 1)'(K);

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          in_run;
    logic [AW:0]   k0, k1;
    logic          v0, v1;
    logic [DW-1:0] d_rd0, d_rd1, w_rd0, w_rd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nx = ST_CLEAR;
                    cnt_nx   = '0;
                end
            end
            ST_CLEAR: begin
                state_nx = ST_FEED;
                cnt_nx   = '0;
            end
            ST_FEED: begin
                if (cnt == CW'(NSTEP - 1)) begin
                    state_nx = ST_DRAIN;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            ST_DRAIN: begin
                if (cnt == CW'(DRAIN_LAT - 1)) begin
                    state_nx = ST_CAPTURE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            ST_CAPTURE: state_nx = ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
    end

    assign in_run = (state == ST_CLEAR) || (state == ST_FEED) || (state == ST_DRAIN);

    // Outputs are registered from the next state so they line up with the state they describe.
    always_comb begin
        k0 = (AW + 1)'({cnt_nx, 1'b0});
        k1 = k0 - (AW + 1)'(1);
        v0 = (state_nx == ST_FEED) && (k0 < KW);
        v1 = (state_nx == ST_FEED) && (cnt_nx != '0) && (k1 < KW);
    end

    sa2x2_ctrl_op_buf #(.DW(DW), .K(K), .AW(AW)) u_data_buf (
        .clk    (clk),
        .rst    (rst),
        .we     (ld_en && !in_run && !ld_sel),
        .waddr  (ld_addr),
        .wdata  (ld_data),
        .raddr0 (k0[AW-1:0]),
        .raddr1 (k1[AW-1:0]),
        .rdata0 (d_rd0),
        .rdata1 (d_rd1)
    );

    sa2x2_ctrl_op_buf #(.DW(DW), .K(K), .AW(AW)) u_weight_buf (
        .clk    (clk),
        .rst    (rst),
        .we     (ld_en && !in_run && ld_sel),
        .waddr  (ld_addr),
        .wdata  (ld_data),
        .raddr0 (k0[AW-1:0]),
        .raddr1 (k1[AW-1:0]),
        .rdata0 (w_rd0),
        .rdata1 (w_rd1)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            sa_clear <= 1'b0;
            sa_din0  <= '0;
            sa_din1  <= '0;
            sa_win0  <= '0;
            sa_win1  <= '0;
        end else begin
            busy     <= (state_nx == ST_CLEAR) || (state_nx == ST_FEED) || (state_nx == ST_DRAIN);
            done     <= (state_nx == ST_CAPTURE);
            sa_clear <= (state_nx == ST_CLEAR);
            if (state_nx == ST_CAPTURE) result <= sa_out;
            sa_din0  <= v0 ? d_rd0 : '0;
            sa_win0  <= v0 ? w_rd0 : '0;
            sa_din1  <= v1 ? d_rd1 : '0;
            sa_win1  <= v1 ? w_rd1 : '0;
        end
    end

endmodule

// File: tb/tb_sa2x2_ctrl.sv
// tb/tb_sa2x2_ctrl.sv - directed self-checking bench for sa2x2_ctrl with a behavioural sa2x2 model
module tb_sa2x2_ctrl;

    localparam int DW = 8;
    localparam int OW = 8;
    localparam int K  = 9;
    localparam int AW = 4;
    localparam int DL = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ld_en = 1'b0;
    logic          ld_sel = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_data = '0;
    logic          start = 1'b0;
    logic          busy, done, sa_clear;
    logic [OW-1:0] result, sa_out;
    logic [DW-1:0] sa_din0, sa_din1, sa_win0, sa_win1;

    sa2x2_ctrl #(.DW(DW), .OW(OW), .K(K), .AW(AW), .DRAIN_LAT(DL)) dut (
        .clk      (clk),
        .rst      (rst),
        .ld_en    (ld_en),
        .ld_sel   (ld_sel),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .sa_clear (sa_clear),
        .sa_din0  (sa_din0),
        .sa_din1  (sa_din1),
        .sa_win0  (sa_win0),
        .sa_win1  (sa_win1),
        .sa_out   (sa_out)
    );

    always #5 clk = ~clk;

    // Array model: three register stages from lane inputs to out (accumulator + two delays).
    logic [OW-1:0] acc, p1, p2;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
            p1  <= '0;
            p2  <= '0;
        end else begin
            acc <= sa_clear ? '0 : acc + OW'(sa_din0 * sa_win0) + OW'(sa_din1 * sa_win1);
            p1  <= acc;
            p2  <= p1;
        end
    end
    assign sa_out = p2;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    logic [DW-1:0] vec_d  [K] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    logic [DW-1:0] vec_w  [K] = '{8'd0, 8'd9, 8'd8, 8'd1, 8'd2, 8'd3, 8'd7, 8'd8, 8'd9};
    logic [DW-1:0] vec_ff [K] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

    logic [DW-1:0] s_din0 [25];
    logic [DW-1:0] s_din1 [25];
    logic [DW-1:0] s_win0 [25];
    logic [DW-1:0] s_win1 [25];
    logic [OW-1:0] s_res  [25];
    logic          s_done [25];
    logic          s_busy [25];
    logic          s_clr  [25];

    task automatic write1(input logic sel, input logic [AW-1:0] a, input logic [DW-1:0] v);
        ld_en = 1'b1; ld_sel = sel; ld_addr = a; ld_data = v;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    task automatic load(input logic sel, input logic [DW-1:0] v [K]);
        for (int i = 0; i < K; i++) write1(sel, AW'(i), v[i]);
    endtask

    // Pulses start, then records cycles 1..24 after the sampling edge. ld_at=0 writes alongside start.
    task automatic run(input int ld_at, input int start_at, input logic [AW-1:0] la, input logic [DW-1:0] lv);
        start = 1'b1;
        ld_en = (ld_at == 0); ld_sel = 1'b0; ld_addr = la; ld_data = lv;
        @(posedge clk); #1;
        for (int n = 1; n < 25; n++) begin
            s_din0[n] = sa_din0; s_din1[n] = sa_din1;
            s_win0[n] = sa_win0; s_win1[n] = sa_win1;
            s_res[n]  = result;  s_done[n] = done;
            s_busy[n] = busy;    s_clr[n]  = sa_clear;
            start = (n == start_at);
            ld_en = (n == ld_at);
            @(posedge clk); #1;
        end
        start = 1'b0;
        ld_en = 1'b0;
    endtask

    function automatic int first_done();
        for (int n = 1; n < 25; n++) if (s_done[n]) return n;
        return -1;
    endfunction

    function automatic int count_done();
        int c = 0;
        for (int n = 1; n < 25; n++) c += int'(s_done[n]);
        return c;
    endfunction

    function automatic int count_busy();
        int c = 0;
        for (int n = 1; n < 25; n++) c += int'(s_busy[n]);
        return c;
    endfunction

    int dcnt;
    logic [DW-1:0] exp_d0 [5] = '{8'd1, 8'd3, 8'd5, 8'd7, 8'd9};
    logic [DW-1:0] exp_d1 [5] = '{8'd0, 8'd2, 8'd4, 8'd6, 8'd8};

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy_done_clr", 32'({busy, done, sa_clear}), 0);
        check("reset_result", 32'(result), 0);
        check("reset_lanes", 32'({sa_din0, sa_din1, sa_win0, sa_win1}), 0);
        rst = 1'b1;
        @(posedge clk); #1;

        // 1 + 2: basic run, latency, result and lane stream
        load(1'b0, vec_d);
        load(1'b1, vec_w);
        run(-1, -1, '0, '0);
        check("t1_done_latency", 32'(first_done()), 10);
        check("t1_result", 32'(s_res[10]), 12);
        check("t1_busy_cycles", 32'(count_busy()), 9);
        check("t1_busy_low_at_done", 32'(s_busy[10]), 0);
        check("t1_done_count", 32'(count_done()), 1);
        check("t2_clear_before_feed", 32'({s_clr[1], s_clr[2]}), 32'b10);
        for (int s = 0; s < 5; s++) begin
            check($sformatf("t2_din0_s%0d", s), 32'(s_din0[s + 2]), 32'(exp_d0[s]));
            check($sformatf("t2_din1_s%0d", s), 32'(s_din1[s + 2]), 32'(exp_d1[s]));
        end
        check("t2_win1_first", 32'(s_win1[2]), 0);
        check("t2_win0_step1", 32'(s_win0[3]), 8);
        check("t2_win1_last", 32'(s_win1[6]), 8);
        check("t2_lanes_idle_after", 32'({s_din0[7], s_din1[7], s_win0[7], s_win1[7]}), 0);

        // 3: start and load while busy are ignored
        run(5, 4, 4'd0, 8'hFF);
        check("t3_done_latency", 32'(first_done()), 10);
        check("t3_result", 32'(s_res[10]), 12);
        check("t3_no_queued_run", 32'(count_done()), 1);
        run(-1, -1, '0, '0);
        check("t3_data0_kept", 32'(s_din0[2]), 1);
        check("t3_rerun_result", 32'(s_res[10]), 12);

        // 4: reset during FEED step 2
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("t4_mid_feed_din0", 32'(sa_din0), 5);
        #2 rst = 1'b0;
        #1;
        check("t4_rst_flags", 32'({busy, done, sa_clear}), 0);
        check("t4_rst_lanes", 32'({sa_din0, sa_din1, sa_win0, sa_win1}), 0);
        check("t4_rst_result", 32'(result), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        dcnt = 0;
        repeat (15) begin @(posedge clk); #1; dcnt += int'(done) + int'(busy); end
        check("t4_no_done_after_abort", 32'(dcnt), 0);
        load(1'b0, vec_d);
        load(1'b1, vec_w);
        run(-1, -1, '0, '0);
        check("t4_rerun_result", 32'(s_res[10]), 12);

        // 5: all-ones vectors, then out-of-range writes
        load(1'b0, vec_ff);
        load(1'b1, vec_ff);
        run(-1, -1, '0, '0);
        check("t5_ff_din0", 32'(s_din0[2]), 32'hFF);
        check("t5_ff_din1_step0", 32'(s_din1[2]), 0);
        check("t5_ff_result", 32'(s_res[10]), 32'h09);
        write1(1'b0, 4'd9, 8'h00);
        write1(1'b1, 4'd9, 8'h00);
        run(-1, -1, '0, '0);
        check("t5_addr9_ignored", 32'(s_res[10]), 32'h09);

        // 6: write and start in the same cycle
        load(1'b0, vec_d);
        load(1'b1, vec_w);
        run(0, -1, 4'd8, 8'h00);
        check("t6_result_held", 32'(s_res[9]), 32'h09);
        check("t6_result", 32'(s_res[10]), 187);
        check("t6_done_latency", 32'(first_done()), 10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
